// File: rtl/bip_pkg.sv
// bip_pkg: shared constants for the BIP control unit.
//   - opcode encodings (5-bit field at IR[15:11])
//   - FSM state encoding
//   - datapath select and ALU op constants
package bip_pkg;

    localparam int INSTR_W = 16;

    localparam logic [4:0] OPC_HLT  = 5'b00000;
    localparam logic [4:0] OPC_STO  = 5'b00001;
    localparam logic [4:0] OPC_LD   = 5'b00010;
    localparam logic [4:0] OPC_LDI  = 5'b00011;
    localparam logic [4:0] OPC_ADD  = 5'b00100;
    localparam logic [4:0] OPC_ADDI = 5'b00101;
    localparam logic [4:0] OPC_SUB  = 5'b00110;
    localparam logic [4:0] OPC_SUBI = 5'b00111;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [1:0] SEL_A_MEM = 2'd0;
    localparam logic [1:0] SEL_A_IMM = 2'd1;
    localparam logic [1:0] SEL_A_ALU = 2'd2;

    localparam logic SEL_B_MEM = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/bip_control_if.sv
// bip_control_if: bundle between the control unit, program memory and the
// accumulator/ALU datapath.
//   master modport : the control unit (consumes start/instruction, drives the rest)
//   slave modport  : the environment (program memory, datapath, debug host)
// Signals:
//   i_start, i_instruction         -> into the control unit
//   o_pc, o_operand                -> program-memory / data-memory addressing
//   o_sel_a, o_sel_b, o_op         -> datapath selects
//   o_wr_acc, o_rd_ram, o_wr_ram   -> strobes
//   o_busy, o_halted, o_cycles     -> status / debug
interface bip_control_if #(
    parameter int OPERAND_W = 11,
    parameter int PC_W      = 11,
    parameter int CYCLE_W   = 16,
    parameter int INSTR_W   = 16
) ();

    logic                 i_start;
    logic [INSTR_W-1:0]   i_instruction;
    logic [PC_W-1:0]      o_pc;
    logic [OPERAND_W-1:0] o_operand;
    logic [1:0]           o_sel_a;
    logic                 o_sel_b;
    logic                 o_op;
    logic                 o_wr_acc;
    logic                 o_rd_ram;
    logic                 o_wr_ram;
    logic                 o_busy;
    logic                 o_halted;
    logic [CYCLE_W-1:0]   o_cycles;

    modport master (
        input  i_start, i_instruction,
        output o_pc, o_operand, o_sel_a, o_sel_b, o_op,
               o_wr_acc, o_rd_ram, o_wr_ram, o_busy, o_halted, o_cycles
    );

    modport slave (
        output i_start, i_instruction,
        input  o_pc, o_operand, o_sel_a, o_sel_b, o_op,
               o_wr_acc, o_rd_ram, o_wr_ram, o_busy, o_halted, o_cycles
    );

endinterface

// File: rtl/bip_decoder.sv
// bip_decoder: purely combinational opcode decode.
// Ports:
//   i_opcode  : IR[15:11]
//   o_sel_a   : accumulator source select
//   o_sel_b   : ALU operand B select
//   o_op      : ALU add/sub
//   o_wr_acc  : accumulator write (used in EXEC)
//   o_wr_ram  : data-memory write (used in EXEC)
//   o_rd_mem  : data-memory read (used in DECODE)
// Outputs are not state-qualified here; the control unit gates them.
module bip_decoder
    import bip_pkg::*;
(
    input  logic [4:0] i_opcode,
    output logic [1:0] o_sel_a,
    output logic       o_sel_b,
    output logic       o_op,
    output logic       o_wr_acc,
    output logic       o_wr_ram,
    output logic       o_rd_mem
);

    always_comb begin
        o_sel_a  = SEL_A_MEM;
        o_sel_b  = SEL_B_MEM;
        o_op     = OP_ADD;
        o_wr_acc = 1'b0;
        o_wr_ram = 1'b0;
        o_rd_mem = 1'b0;
        case (i_opcode)
            OPC_STO: begin
                o_wr_ram = 1'b1;
            end
            OPC_LD: begin
                o_rd_mem = 1'b1;
                o_wr_acc = 1'b1;
                o_sel_a  = SEL_A_MEM;
            end
            OPC_LDI: begin
                o_wr_acc = 1'b1;
                o_sel_a  = SEL_A_IMM;
            end
            OPC_ADD: begin
                o_rd_mem = 1'b1;
                o_wr_acc = 1'b1;
                o_sel_a  = SEL_A_ALU;
                o_sel_b  = SEL_B_MEM;
                o_op     = OP_ADD;
            end
            OPC_ADDI: begin
                o_wr_acc = 1'b1;
                o_sel_a  = SEL_A_ALU;
                o_sel_b  = SEL_B_IMM;
                o_op     = OP_ADD;
            end
            OPC_SUB: begin
                o_rd_mem = 1'b1;
                o_wr_acc = 1'b1;
                o_sel_a  = SEL_A_ALU;
                o_sel_b  = SEL_B_MEM;
                o_op     = OP_SUB;
            end
            OPC_SUBI: begin
                o_wr_acc = 1'b1;
                o_sel_a  = SEL_A_ALU;
                o_sel_b  = SEL_B_IMM;
                o_op     = OP_SUB;
            end
            // HLT is handled by the FSM; 01000-11111 are NOPs.
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/bip_control.sv
// bip_control: multi-cycle BIP control unit (FETCH/DECODE/EXEC).
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : bip_control_if.master
//            i_start        - leave IDLE, begin at PC 0
//            i_instruction  - program memory data for address o_pc
//            o_pc           - program counter
//            o_operand      - IR[10:0]
//            o_sel_a/o_sel_b/o_op - datapath selects
//            o_wr_acc/o_rd_ram/o_wr_ram - strobes
//            o_busy/o_halted/o_cycles   - status and debug cycle counter
module bip_control
    import bip_pkg::*;
#(
    parameter int OPCODE_W  = 5,
    parameter int OPERAND_W = 11,
    parameter int PC_W      = 11,
    parameter int CYCLE_W   = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    bip_control_if.master bus
);

    localparam int IR_W = OPCODE_W + OPERAND_W;
    localparam logic [CYCLE_W-1:0] CYC_ONE = CYCLE_W'(1);
    localparam logic [PC_W-1:0]    PC_ONE  = PC_W'(1);

    state_t               r_state;
    logic [PC_W-1:0]      r_pc;
    logic [IR_W-1:0]      r_ir;
    logic [CYCLE_W-1:0]   r_cycles;

    logic [OPCODE_W-1:0]  w_opcode;
    logic                 w_active;
    logic [1:0]           w_dec_sel_a;
    logic                 w_dec_sel_b;
    logic                 w_dec_op;
    logic                 w_dec_wr_acc;
    logic                 w_dec_wr_ram;
    logic                 w_dec_rd_mem;
    logic [1:0]           w_sel_a;
    logic                 w_sel_b;
    logic                 w_op;
    logic                 w_wr_acc;
    logic                 w_wr_ram;
    logic                 w_rd_ram;

    assign w_opcode = r_ir[IR_W-1 -: OPCODE_W];
    assign w_active = (r_state == S_FETCH) || (r_state == S_DECODE) ||
                      (r_state == S_EXEC);

    bip_decoder u_decoder (
        .i_opcode (w_opcode),
        .o_sel_a  (w_dec_sel_a),
        .o_sel_b  (w_dec_sel_b),
        .o_op     (w_dec_op),
        .o_wr_acc (w_dec_wr_acc),
        .o_wr_ram (w_dec_wr_ram),
        .o_rd_mem (w_dec_rd_mem)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_pc     <= '0;
            r_ir     <= '0;
            r_cycles <= '0;
        end else begin
            // Debug counter saturates rather than wrapping.
            if (w_active && (r_cycles != '1)) begin
                r_cycles <= r_cycles + CYC_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_ir    <= bus.i_instruction;
                    r_state <= S_DECODE;
                end
                S_DECODE: begin
                    r_state <= (w_opcode == OPC_HLT) ? S_HALT : S_EXEC;
                end
                S_EXEC: begin
                    r_pc    <= r_pc + PC_ONE;
                    r_state <= S_FETCH;
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are a combinational function of state and IR so that an
    // asynchronous reset (state -> IDLE) removes them immediately.
    always_comb begin
        w_sel_a  = SEL_A_MEM;
        w_sel_b  = SEL_B_MEM;
        w_op     = OP_ADD;
        w_wr_acc = 1'b0;
        w_wr_ram = 1'b0;
        w_rd_ram = 1'b0;
        if (r_state == S_EXEC) begin
            w_sel_a  = w_dec_sel_a;
            w_sel_b  = w_dec_sel_b;
            w_op     = w_dec_op;
            w_wr_acc = w_dec_wr_acc;
            w_wr_ram = w_dec_wr_ram;
        end else if (r_state == S_DECODE) begin
            // Synchronous-read data memory: address + read in DECODE,
            // data available in EXEC.
            w_rd_ram = w_dec_rd_mem;
        end
    end

    assign bus.o_pc      = r_pc;
    assign bus.o_operand = r_ir[OPERAND_W-1:0];
    assign bus.o_sel_a   = w_sel_a;
    assign bus.o_sel_b   = w_sel_b;
    assign bus.o_op      = w_op;
    assign bus.o_wr_acc  = w_wr_acc;
    assign bus.o_wr_ram  = w_wr_ram;
    assign bus.o_rd_ram  = w_rd_ram;
    assign bus.o_busy    = w_active;
    assign bus.o_halted  = (r_state == S_HALT);
    assign bus.o_cycles  = r_cycles;

endmodule

// File: tb/tb_bip_control.sv
// Testbench for bip_control. Expected strobe events are queued by the
// stimulus process; a monitor pops and compares one entry every time the
// DUT raises any strobe. Status values are checked directly.
module tb_bip_control;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    bip_control_if #(
        .OPERAND_W (11),
        .PC_W      (11),
        .CYCLE_W   (16),
        .INSTR_W   (16)
    ) bus ();

    bip_control #(
        .OPCODE_W  (5),
        .OPERAND_W (11),
        .PC_W      (11),
        .CYCLE_W   (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [15:0] prog [0:2047];
    assign bus.i_instruction = prog[bus.o_pc];

    typedef struct {
        logic [10:0] pc;
        logic [10:0] opnd;
        logic        rd;
        logic        wa;
        logic        wr;
        logic [1:0]  sa;
        logic        sb;
        logic        op;
        logic [15:0] cyc;
    } ev_t;

    ev_t exp_q[$];
    int  errors = 0;
    int  checks = 0;

    task automatic push_ev(input logic [10:0] pc, input logic [10:0] opnd,
                           input logic rd, input logic wa, input logic wr,
                           input logic [1:0] sa, input logic sb, input logic op,
                           input logic [15:0] cyc);
        ev_t e;
        e.pc = pc; e.opnd = opnd; e.rd = rd; e.wa = wa; e.wr = wr;
        e.sa = sa; e.sb = sb; e.op = op; e.cyc = cyc;
        exp_q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.i_start = 1'b1;
        @(negedge clk) bus.i_start = 1'b0;
    endtask

    // Monitor: every strobe event must match the head of the queue.
    ev_t m_e;
    always @(negedge clk) begin
        if (rst_n && (bus.o_rd_ram || bus.o_wr_acc || bus.o_wr_ram)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: pc=%0h rd=%0b wa=%0b wr=%0b cyc=%0d, none expected",
                         bus.o_pc, bus.o_rd_ram, bus.o_wr_acc, bus.o_wr_ram, bus.o_cycles);
            end else begin
                m_e = exp_q.pop_front();
                if (bus.o_pc !== m_e.pc || bus.o_operand !== m_e.opnd ||
                    bus.o_rd_ram !== m_e.rd || bus.o_wr_acc !== m_e.wa ||
                    bus.o_wr_ram !== m_e.wr || bus.o_sel_a !== m_e.sa ||
                    bus.o_sel_b !== m_e.sb || bus.o_op !== m_e.op ||
                    bus.o_cycles !== m_e.cyc) begin
                    errors++;
                    $display("FAIL strobe_event: got pc=%0h opnd=%0h rd=%0b wa=%0b wr=%0b sa=%0d sb=%0b op=%0b cyc=%0d expected pc=%0h opnd=%0h rd=%0b wa=%0b wr=%0b sa=%0d sb=%0b op=%0b cyc=%0d",
                             bus.o_pc, bus.o_operand, bus.o_rd_ram, bus.o_wr_acc, bus.o_wr_ram,
                             bus.o_sel_a, bus.o_sel_b, bus.o_op, bus.o_cycles,
                             m_e.pc, m_e.opnd, m_e.rd, m_e.wa, m_e.wr, m_e.sa, m_e.sb, m_e.op, m_e.cyc);
                end
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < 2048; i++) prog[i] = 16'hFFFF;
        bus.i_start = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        chk("rst_pc",      32'(bus.o_pc), 32'h0);
        chk("rst_cycles",  32'(bus.o_cycles), 32'h0);
        chk("rst_operand", 32'(bus.o_operand), 32'h0);
        chk("rst_status",  {30'b0, bus.o_busy, bus.o_halted}, 32'h0);
        chk("rst_strobes", {24'b0, bus.o_sel_a, bus.o_sel_b, bus.o_op,
                            bus.o_wr_acc, bus.o_rd_ram, bus.o_wr_ram, 1'b0}, 32'h0);
        @(negedge clk) rst_n = 1'b1;

        // Idle without start
        repeat (10) @(negedge clk);
        chk("idle_pc",     32'(bus.o_pc), 32'h0);
        chk("idle_cycles", 32'(bus.o_cycles), 32'h0);
        chk("idle_busy",   32'(bus.o_busy), 32'h0);

        // Run A: LDI, ADD, SUBI, STO, HLT
        prog[0] = 16'h1D8E;
        prog[1] = 16'h2005;
        prog[2] = 16'h398E;
        prog[3] = 16'h0807;
        prog[4] = 16'h0000;
        push_ev(11'd0, 11'h58E, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 16'd2);  // LDI exec
        push_ev(11'd1, 11'h005, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'd4);  // ADD decode read
        push_ev(11'd1, 11'h005, 1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 16'd5);  // ADD exec
        push_ev(11'd2, 11'h18E, 1'b0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 16'd8);  // SUBI exec
        push_ev(11'd3, 11'h007, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd11); // STO exec
        pulse_start();
        n = 0;
        while (!bus.o_halted && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("halt_reached", 32'(bus.o_halted), 32'h1);
        chk("halt_pc",      32'(bus.o_pc), 32'h4);
        chk("halt_cycles",  32'(bus.o_cycles), 32'd14);
        chk("halt_busy",    32'(bus.o_busy), 32'h0);
        chk("run_a_drained", 32'(exp_q.size()), 32'h0);
        pulse_start();
        repeat (5) @(negedge clk);
        chk("halt_start_pc",     32'(bus.o_pc), 32'h4);
        chk("halt_start_cycles", 32'(bus.o_cycles), 32'd14);
        chk("halt_start_halted", 32'(bus.o_halted), 32'h1);

        // Run B: reset during STO execute
        #1 rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        chk("rst2_halted", 32'(bus.o_halted), 32'h0);
        prog[0] = 16'h0807;
        push_ev(11'd0, 11'h007, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 16'd2);
        pulse_start();
        n = 0;
        while (!bus.o_wr_ram && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("sto_seen", 32'(bus.o_wr_ram), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_wr_ram", 32'(bus.o_wr_ram), 32'h0);
        chk("midrst_busy",   32'(bus.o_busy), 32'h0);
        chk("midrst_pc",     32'(bus.o_pc), 32'h0);
        chk("midrst_cycles", 32'(bus.o_cycles), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_idle", 32'(bus.o_busy), 32'h0);

        // Run C: all NOPs (opcode 11111), PC wraps after 2048 instructions
        for (int i = 0; i < 2048; i++) prog[i] = 16'hFFFF;
        pulse_start();
        n = 0;
        while (bus.o_pc != 11'd2047 && n < 7000) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_reach_2047", 32'(bus.o_pc), 32'd2047);
        n = 0;
        while (bus.o_pc == 11'd2047 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("wrap_pc",      32'(bus.o_pc), 32'h0);
        chk("wrap_cycles",  32'(bus.o_cycles), 32'd6144);
        chk("wrap_busy",    32'(bus.o_busy), 32'h1);
        chk("wrap_operand", 32'(bus.o_operand), 32'h7FF);

        repeat (2) @(negedge clk);
        chk("final_drained", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bip_control.md
# bip_control

Multi-cycle control unit for the BIP processor. It fetches 16-bit instructions (opcode[15:11], operand[10:0]) from program memory and owns the program counter. It sequences each instruction through FETCH/DECODE/EXEC and drives the datapath selects, the accumulator write, the ALU add/sub select and the data-memory strobes. The raw 11-bit operand goes to SIGNAL_EXTENSION and to the data-memory address. It sits between program memory and the accumulator/ALU datapath, and also keeps an execution-cycle counter for debug.

## Interface
- OPCODE_W, 5, opcode field width
- OPERAND_W, 11, operand field width (also data-memory address width)
- PC_W, 11, program counter width
- CYCLE_W, 16, execution-cycle counter width
---
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  leave IDLE and begin execution at PC 0
- i_instruction  in  16  program-memory read data (combinational read of o_pc)
- o_pc  out  PC_W  program-memory address
- o_operand  out  OPERAND_W  IR[10:0], feeds SIGNAL_EXTENSION and data-memory address
- o_sel_a  out  2  accumulator source: 0 data mem, 1 sign-extended imm, 2 ALU result
- o_sel_b  out  1  ALU operand B: 0 data mem, 1 sign-extended imm
- o_op  out  1  ALU op: 0 add, 1 sub
- o_wr_acc  out  1  accumulator write enable
- o_rd_ram  out  1  data-memory read strobe
- o_wr_ram  out  1  data-memory write strobe (stores ACC)
- o_busy  out  1  high in FETCH/DECODE/EXEC
- o_halted  out  1  high in HALT
- o_cycles  out  CYCLE_W  clocks spent in FETCH/DECODE/EXEC

## Operation
- Opcodes:
  - HLT 00000
  - STO 00001
  - LD 00010
  - LDI 00011
  - ADD 00100
  - ADDI 00101
  - SUB 00110
  - SUBI 00111
  - 01000–11111 execute as NOP.
- States:
  - IDLE: waits for i_start, then goes to FETCH.
  - FETCH: IR <= i_instruction, then goes to DECODE.
  - DECODE: HLT goes to HALT; everything else goes to EXEC.
  - EXEC: PC <= PC+1, then goes to FETCH.
  - HALT: absorbing; left only by reset.
- DECODE: o_rd_ram=1 for LD, ADD and SUB.
- EXEC strobes, each high for exactly one cycle:
  - STO: o_wr_ram.
  - LD: o_wr_acc, sel_a=0.
  - LDI: o_wr_acc, sel_a=1.
  - ADD/SUB: o_wr_acc, sel_a=2, sel_b=0, op=0/1.
  - ADDI/SUBI: o_wr_acc, sel_a=2, sel_b=1, op=0/1.
  - NOP: no strobes.
- Strobes are low in every other state; selects are don't-care when no strobe is active but are driven to 0.
- o_operand = IR[10:0] at all times.
- PC wraps from 2^PC_W-1 to 0 silently.
- o_cycles increments in FETCH/DECODE/EXEC and saturates at all-ones; it holds in IDLE and HALT.
- i_start is ignored outside IDLE.

## Timing
- Reset values:
  - State IDLE; PC 0; IR 0; o_cycles 0.
  - All strobes 0; selects 0; o_busy 0; o_halted 0.
- CPI is 3 for every non-HLT instruction. HLT takes 2 cycles; PC stays at the HLT address.
- i_start sampled high in IDLE puts the FSM in FETCH on the next edge.
- Data memory is synchronous-read: the address and o_rd_ram are presented in DECODE, and data is valid in EXEC.
- Strobes and selects are combinational decode of state and IR, with no added latency.
- Reset asserted mid-instruction forces IDLE immediately (asynchronously). No partial write may follow: strobes drop with reset.

## Structure
- Package bip_pkg:
  - opcode localparams
  - state encoding (IDLE, FETCH, DECODE, EXEC, HALT)
  - SEL_A_MEM/IMM/ALU and SEL_B_MEM/IMM constants
  - OP_ADD/OP_SUB
- Sub-module bip_decoder: purely combinational, opcode to {sel_a, sel_b, op, wr_acc, wr_ram, rd_mem}. bip_control gates its outputs with the state.

## Test plan
- **Reset then idle:** rst_n low then high, no i_start, 10 clocks → o_pc=0, o_cycles=0, o_busy=0, all strobes 0.
- **LDI:** program[0]=0x1D8E (LDI operand 11'b10110001110); pulse i_start → o_operand=0x58E; o_wr_acc=1 and sel_a=1 in the 3rd cycle after start only; o_pc=1 afterwards.
- **ADD from memory:** program[1]=0x2005 (ADD 5) → o_rd_ram=1 in DECODE; in EXEC o_wr_acc=1, sel_a=2, sel_b=0, op=0.
- **SUBI, STO, unknown opcode:**
  - SUBI 0x18E → EXEC op=1, sel_b=1.
  - STO 7 → only o_wr_ram high in EXEC.
  - Opcode 11111 → no strobes, PC still advances.
- **HLT:** program[4]=0x0000 → o_halted=1 two cycles after FETCH; o_pc stays 4; o_cycles frozen at 14; a later i_start has no effect.
- **Reset mid-EXEC and PC wrap:** rst_n low during a STO EXEC → o_wr_ram drops at once, state IDLE, PC 0. Force PC to 2047 with a NOP → next PC 0.
